// File: rtl/mk14_vdu_pkg.sv
// Shared types and default widths for the MK14 VDU / CPU display-RAM arbiter.
package mk14_vdu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        G_NONE  = 2'd0,
        G_VDU   = 2'd1,
        G_DRAIN = 2'd2,
        G_CPURD = 2'd3
    } grant_t;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 8;
    localparam int WBUF_DEPTH_DEF = 4;

endpackage

// File: rtl/mk14_vdu_mem_arb_chk.sv
// Protocol and safety properties for the display-RAM arbiter.
module mk14_vdu_mem_arb_chk #(
    parameter int ADDR_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    input logic              vdu_read_en,
    input logic              mem_en,
    input logic              mem_we,
    input logic              push,
    input logic              pop,
    input logic              full,
    input logic              empty,
    input logic              cpu_req,
    input logic              cpu_ready,
    input logic              cpu_we,
    input logic [ADDR_W-1:0] cpu_addr
);
    a_no_write_during_vdu: assert property (@(posedge clk) disable iff (!rst_n)
        !(vdu_read_en && mem_en && mem_we));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty));

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (cpu_req && !cpu_ready) |=> (!cpu_req || ($stable(cpu_we) && $stable(cpu_addr))));

endmodule

// File: rtl/mk14_wbuf.sv
// Posted-write FIFO: power-of-two depth, pointers wrap naturally, a full buffer refuses pushes.
module mk14_wbuf #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  store_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_s;
    logic          pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    // Full blocks the push even when the same cycle pops.
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;
    assign head_o  = store_q[rd_ptr_q];

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (push_s) store_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mk14_vdu_mem_arb.sv
// Arbitrates one single-port display RAM between VDU fetches (absolute priority),
// posted CPU writes and stalling CPU reads.
module mk14_vdu_mem_arb
    import mk14_vdu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic              vdu_read_en,
    input  logic [ADDR_W-1:0] vdu_read_addr,
    output logic [DATA_W-1:0] vdu_display_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              wbuf_full,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int EW = ADDR_W + DATA_W;

    arb_state_t        state_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    grant_t            grant_s;
    logic              push_s;
    logic              pop_s;
    logic              wb_full_s;
    logic              wb_empty_s;
    logic [EW-1:0]     wb_head_s;

    mk14_wbuf #(
        .DEPTH (WBUF_DEPTH),
        .W     (EW)
    ) u_wbuf (
        .clk     (clk_pix),
        .rst_n   (rst_pix_n),
        .push_i  (push_s),
        .din_i   ({cpu_addr, cpu_wdata}),
        .pop_i   (pop_s),
        .full_o  (wb_full_s),
        .empty_o (wb_empty_s),
        .head_o  (wb_head_s)
    );

    // Writes are only accepted from IDLE so a read in flight never races a push.
    assign push_s           = (state_q == IDLE) & cpu_req & cpu_we & ~wb_full_s;
    assign pop_s            = (grant_s == G_DRAIN);
    assign cpu_ready        = push_s | (state_q == RD_DONE);
    assign cpu_rdata        = cpu_rdata_q;
    assign wbuf_full        = wb_full_s;
    assign vdu_display_data = mem_rdata;

    // Per-cycle RAM grant: VDU, then buffer drain, then CPU read issue.
    always_comb begin
        grant_s = G_NONE;
        if (vdu_read_en) begin
            grant_s = G_VDU;
        end else if (!wb_empty_s) begin
            grant_s = G_DRAIN;
        end else if ((state_q == IDLE) && cpu_req && !cpu_we) begin
            grant_s = G_CPURD;
        end else begin
            grant_s = G_NONE;
        end
    end

    // RAM port mux driven from the current grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        case (grant_s)
            G_VDU: begin
                mem_en   = 1'b1;
                mem_addr = vdu_read_addr;
            end
            G_DRAIN: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wb_head_s[EW-1:DATA_W];
                mem_wdata = wb_head_s[DATA_W-1:0];
            end
            G_CPURD: begin
                mem_en   = 1'b1;
                mem_addr = cpu_addr;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // CPU read sequencer with registered read data.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q     <= IDLE;
            cpu_rdata_q <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_s == G_CPURD) state_q <= RD_WAIT;
                    else                    state_q <= IDLE;
                end
                RD_WAIT: begin
                    cpu_rdata_q <= mem_rdata;
                    state_q     <= RD_DONE;
                end
                RD_DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    mk14_vdu_mem_arb_chk #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk         (clk_pix),
        .rst_n       (rst_pix_n),
        .vdu_read_en (vdu_read_en),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .push        (push_s),
        .pop         (pop_s),
        .full        (wb_full_s),
        .empty       (wb_empty_s),
        .cpu_req     (cpu_req),
        .cpu_ready   (cpu_ready),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr)
    );

endmodule

// File: tb/tb_mk14_vdu_mem_arb.sv
// Bench for mk14_vdu_mem_arb: RAM model, scoreboards for VDU data, RAM writes and CPU reads.
module tb_mk14_vdu_mem_arb;

    logic        clk_pix = 1'b0;
    logic        rst_pix_n;
    logic        vdu_read_en;
    logic [15:0] vdu_read_addr;
    logic [7:0]  vdu_display_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [7:0]  cpu_rdata;
    logic        wbuf_full;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        ram_load;
    logic [7:0]  ram  [0:65535];
    logic [7:0]  gold [0:65535];

    logic [7:0]  vdu_q [$];
    logic [23:0] wr_q  [$];
    logic [7:0]  rd_q  [$];
    logic        vdu_pend;
    logic        ready_s;
    int          n_tests;
    int          n_fail;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          vdu_n;
        int          exp_lat;
        logic [7:0]  exp_rdata;
    } vec_t;
    vec_t vecs [4];

    always #5 clk_pix = ~clk_pix;

    mk14_vdu_mem_arb dut (
        .clk_pix          (clk_pix),
        .rst_pix_n        (rst_pix_n),
        .vdu_read_en      (vdu_read_en),
        .vdu_read_addr    (vdu_read_addr),
        .vdu_display_data (vdu_display_data),
        .cpu_req          (cpu_req),
        .cpu_we           (cpu_we),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_ready        (cpu_ready),
        .cpu_rdata        (cpu_rdata),
        .wbuf_full        (wbuf_full),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    // Synchronous single-port RAM, 1-cycle read latency; ram_load restores the addr[7:0] pattern.
    always @(posedge clk_pix) begin
        if (ram_load) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got none expected event", name);
    endtask

    // Observe the current cycle after inputs settle, update scoreboards.
    task automatic settle();
        logic [23:0] e;
        #1;
        if (vdu_pend) begin
            if (vdu_q.size() == 0) fail_now("vdu_q_empty");
            else chk("vdu_data", 32'(vdu_display_data), 32'(vdu_q.pop_front()));
        end
        vdu_pend = vdu_read_en;
        if (vdu_read_en) vdu_q.push_back(ram[vdu_read_addr]);
        if (mem_en && mem_we) begin
            if (wr_q.size() == 0) fail_now("unexpected_mem_write");
            else begin
                e = wr_q.pop_front();
                chk("drain_addr", 32'(mem_addr), 32'(e[23:8]));
                chk("drain_data", 32'(mem_wdata), 32'(e[7:0]));
            end
        end
        ready_s = cpu_ready;
        if (cpu_ready && !cpu_req) fail_now("spurious_ready");
        if (cpu_ready && cpu_req && cpu_we) begin
            wr_q.push_back({cpu_addr, cpu_wdata});
            gold[cpu_addr] = cpu_wdata;
        end
        if (cpu_ready && cpu_req && !cpu_we) begin
            if (rd_q.size() == 0) fail_now("rd_q_empty");
            else chk("cpu_rdata_sb", 32'(cpu_rdata), 32'(rd_q.pop_front()));
        end
    endtask

    task automatic adv();
        @(posedge clk_pix);
        @(negedge clk_pix);
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int lat);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; lat = -1;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (ready_s) begin lat = k; adv(); break; end
            adv();
        end
        cpu_req = 1'b0;
        if (lat < 0) fail_now("write_timeout");
    endtask

    // Read with the VDU held busy for the first vdu_n cycles of the request.
    task automatic cpu_read(input logic [15:0] a, input int vdu_n, output int lat, output logic [7:0] rd);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; lat = -1; rd = 8'h00;
        rd_q.push_back(gold[a]);
        for (int k = 0; k < 40; k++) begin
            vdu_read_en = (k < vdu_n);
            settle();
            if (ready_s) begin lat = k; rd = cpu_rdata; adv(); break; end
            adv();
        end
        cpu_req = 1'b0;
        vdu_read_en = 1'b0;
        if (lat < 0) fail_now("read_timeout");
    endtask

    task automatic cpu_rand_step();
        if (!cpu_req && ($urandom_range(0, 2) == 0)) begin
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'h3000 + 16'($urandom_range(0, 15));
            cpu_wdata = 8'($urandom);
            if (!cpu_we) rd_q.push_back(gold[cpu_addr]);
            cpu_req = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int done = 0;
        for (int k = 0; k < 100; k++) begin
            if (!cpu_req && wr_q.size() == 0) begin done = 1; break; end
            settle();
            if (ready_s) cpu_req = 1'b0;
            adv();
        end
        if (done == 0) fail_now("idle_timeout");
    endtask

    initial begin
        int         lat;
        logic [7:0] rd;
        logic       early;
        n_tests = 0; n_fail = 0; vdu_pend = 1'b0; ready_s = 1'b0;
        vecs[0] = '{16'h0205, 8'h55, 0, 3, 8'h55};
        vecs[1] = '{16'h1234, 8'hA5, 1, 4, 8'hA5};
        vecs[2] = '{16'hFFFF, 8'h00, 2, 5, 8'h00};
        vecs[3] = '{16'h0000, 8'hFF, 5, 8, 8'hFF};
        for (int i = 0; i < 65536; i++) gold[i] = 8'(i);
        rst_pix_n = 1'b0; ram_load = 1'b1;
        vdu_read_en = 1'b0; vdu_read_addr = 16'h0100;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        @(negedge clk_pix);
        ram_load = 1'b0;
        #1;
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_wbuf_full", 32'(wbuf_full), 32'd0);
        adv();
        rst_pix_n = 1'b1;
        adv();

        // Plain read: ready two cycles after issue.
        cpu_read(16'h00AB, 0, lat, rd);
        chk("rd_min_latency", 32'(lat), 32'd2);
        chk("rd_data_ab", 32'(rd), 32'h000000AB);

        // Reset mid-drain with three entries queued.
        vdu_read_en = 1'b1;
        for (int i = 0; i < 3; i++) cpu_write(16'h0400 + 16'(i), 8'h60 + 8'(i), lat);
        vdu_read_en = 1'b0;
        cyc();
        rst_pix_n = 1'b0;
        wr_q.delete(); vdu_q.delete(); vdu_pend = 1'b0;
        adv(); adv();
        rst_pix_n = 1'b1;
        settle();
        chk("t1_mem_en", 32'(mem_en), 32'd0);
        chk("t1_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("t1_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("t1_wbuf_full", 32'(wbuf_full), 32'd0);
        adv();
        settle();
        chk("t1_empty", 32'(mem_en), 32'd0);
        adv();

        // VDU busy 10 cycles; posted write drains only when it drops.
        vdu_read_en = 1'b1; vdu_read_addr = 16'h0123;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h41;
        settle();
        chk("t2_ready_same_cycle", 32'(cpu_ready), 32'd1);
        chk("t2_no_we_vdu", 32'(mem_we), 32'd0);
        adv();
        cpu_req = 1'b0; early = 1'b0;
        for (int i = 1; i < 10; i++) begin
            settle();
            if (mem_we) early = 1'b1;
            adv();
        end
        chk("t2_no_early_write", 32'(early), 32'd0);
        vdu_read_en = 1'b0;
        settle();
        chk("t2_we", 32'(mem_we), 32'd1);
        chk("t2_addr", 32'(mem_addr), 32'h0200);
        chk("t2_data", 32'(mem_wdata), 32'h41);
        adv();
        wait_idle();

        // Five back-to-back writes against a busy VDU.
        vdu_read_en = 1'b1;
        cpu_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_req = 1'b1; cpu_addr = 16'h0300 + 16'(i); cpu_wdata = 8'h10 + 8'(i);
            if (i < 4) begin
                settle();
                chk("t3_accept", 32'(cpu_ready), 32'd1);
                adv();
            end
        end
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t3_full", 32'(wbuf_full), 32'd1);
            chk("t3_blocked", 32'(cpu_ready), 32'd0);
            adv();
        end
        vdu_read_en = 1'b0;
        settle();
        chk("t3_first_drain", 32'(mem_we), 32'd1);
        chk("t3_full_blocks_push", 32'(cpu_ready), 32'd0);
        adv();
        settle();
        chk("t3_5th_accept", 32'(cpu_ready), 32'd1);
        adv();
        cpu_req = 1'b0;
        wait_idle();

        // Table: write, then read it back with the VDU busy for vdu_n cycles.
        vdu_read_addr = 16'h0150;
        for (int v = 0; v < 4; v++) begin
            cpu_write(vecs[v].addr, vecs[v].wdata, lat);
            chk("vec_wr_lat", 32'(lat), 32'd0);
            cpu_read(vecs[v].addr, vecs[v].vdu_n, lat, rd);
            chk("vec_rd_lat", 32'(lat), 32'(vecs[v].exp_lat));
            chk("vec_rdata", 32'(rd), 32'(vecs[v].exp_rdata));
        end
        wait_idle();

        // VDU sweeps 0x0200..0x020F under random CPU traffic to 0x3000 region.
        ram_load = 1'b1;
        adv();
        ram_load = 1'b0;
        for (int j = 0; j < 40; j++) begin
            cpu_rand_step();
            vdu_read_en   = (j < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            vdu_read_addr = 16'h0200 + 16'(j % 16);
            settle();
            if (ready_s) begin adv(); cpu_req = 1'b0; end
            else adv();
        end
        vdu_read_en = 1'b0;
        wait_idle();
        cyc();

        // Read pending while VDU goes 1,1,0: issue third cycle, ready two later.
        vdu_read_addr = 16'h0207;
        cpu_read(16'h00C3, 2, lat, rd);
        chk("t6_latency", 32'(lat), 32'd4);
        chk("t6_rdata", 32'(rd), 32'hC3);
        cyc();

        chk("end_wr_q_empty", 32'(wr_q.size()), 32'd0);
        chk("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
